// File: rtl/mmio_burst_initiator_pkg.sv
// Shared types and constants for the mmio burst initiator: word width, FSM
// state encoding and the timeout counter width helper.
package mmio_burst_initiator_pkg;

  localparam int TIA_WORD_WIDTH = 32;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE       = 3'd0;
  localparam state_t S_WR_DATA    = 3'd1;
  localparam state_t S_WR_REQ     = 3'd2;
  localparam state_t S_RD_REQ     = 3'd3;
  localparam state_t S_RD_RELEASE = 3'd4;
  localparam state_t S_RD_PUSH    = 3'd5;
  localparam state_t S_DONE       = 3'd6;
  localparam state_t S_ERROR      = 3'd7;

  // The counter only ever holds 0 .. cycles-1.
  function automatic int timeout_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/mmio_burst_initiator_if.sv
// mmio req/ack bus between a host-side initiator and a memory's host port.
// Reads use a four-phase req/ack; writes are acked in the same cycle.
interface mmio_if;
  import mmio_burst_initiator_pkg::*;

  logic                      read_req;
  logic [TIA_WORD_WIDTH-1:0] read_index;
  logic                      read_ack;
  logic [TIA_WORD_WIDTH-1:0] read_data;
  logic                      write_req;
  logic [TIA_WORD_WIDTH-1:0] write_index;
  logic [TIA_WORD_WIDTH-1:0] write_data;
  logic                      write_ack;

  modport host (
    output read_req, read_index, write_req, write_index, write_data,
    input  read_ack, read_data, write_ack
  );

  modport device (
    input  read_req, read_index, write_req, write_index, write_data,
    output read_ack, read_data, write_ack
  );

endinterface

// File: rtl/mmio_burst_initiator_timeout_counter.sv
// Ack-wait watchdog: cleared by load_i, advances while count_i is high and
// saturates at TIMEOUT_CYCLES-1, which is reported as expired_o.
module mmio_timeout_counter
  import mmio_burst_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic enable_i,
  input  logic load_i,
  input  logic count_i,
  output logic expired_o
);

  localparam int            CW   = timeout_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) cnt_d = '0;
    else if (count_i && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else if (enable_i) cnt_q <= cnt_d;
  end

  assign expired_o = (cnt_q == LAST);

endmodule

// File: rtl/mmio_burst_initiator.sv
// Burst initiator: turns one (base, count, direction) command into a run of
// single-word mmio accesses, fed from / drained to valid/ready streams.
module mmio_burst_initiator
  import mmio_burst_initiator_pkg::*;
#(
  parameter int COUNT_WIDTH    = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable_i,
  // Handshakes: a beat transfers on the rising edge where valid && ready;
  // the sender holds valid and payload stable until that edge.
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [TIA_WORD_WIDTH-1:0] cmd_base_i,
  input  logic [COUNT_WIDTH-1:0]    cmd_count_i,
  input  logic                      wr_valid_i,
  output logic                      wr_ready_o,
  input  logic [TIA_WORD_WIDTH-1:0] wr_data_i,
  output logic                      rd_valid_o,
  input  logic                      rd_ready_i,
  output logic [TIA_WORD_WIDTH-1:0] rd_data_o,
  mmio_if.host                      host_interface,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      error_o,
  output logic                      quiescent_o,
  output state_t                    state_o
);

  state_t                    state_q, state_d;
  logic [TIA_WORD_WIDTH-1:0] index_q, index_d;
  logic [COUNT_WIDTH-1:0]    count_q, count_d;
  logic [TIA_WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [TIA_WORD_WIDTH-1:0] rdata_q, rdata_d;
  logic                      error_q, error_d;
  logic                      last_word, expired, tmr_load, tmr_count;

  assign last_word = (count_q == COUNT_WIDTH'(1));

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    error_d = error_q;
    case (state_q)
      S_IDLE: if (cmd_valid_i) begin
        index_d = cmd_base_i;
        count_d = cmd_count_i;
        error_d = 1'b0;
        if (cmd_count_i == '0) state_d = S_DONE;
        else if (cmd_write_i)  state_d = S_WR_DATA;
        else                   state_d = S_RD_REQ;
      end
      S_WR_DATA: if (wr_valid_i) begin
        wdata_d = wr_data_i;
        state_d = S_WR_REQ;
      end
      S_WR_REQ: if (host_interface.write_ack) begin
        index_d = index_q + 1'b1;
        count_d = count_q - 1'b1;
        state_d = last_word ? S_DONE : S_WR_DATA;
      end else if (expired) begin
        state_d = S_ERROR;
        error_d = 1'b1;
      end
      S_RD_REQ: if (host_interface.read_ack) begin
        rdata_d = host_interface.read_data;
        state_d = S_RD_RELEASE;
      end else if (expired) begin
        state_d = S_ERROR;
        error_d = 1'b1;
      end
      // The device only lowers ack while req is still high, so hold req here.
      S_RD_RELEASE: if (!host_interface.read_ack) begin
        state_d = S_RD_PUSH;
      end else if (expired) begin
        state_d = S_ERROR;
        error_d = 1'b1;
      end
      S_RD_PUSH: if (rd_ready_i) begin
        index_d = index_q + 1'b1;
        count_d = count_q - 1'b1;
        state_d = last_word ? S_DONE : S_RD_REQ;
      end
      S_DONE:  state_d = S_IDLE;
      S_ERROR: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      index_q <= '0;
      count_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else if (enable_i) begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  // Every state change restarts the watchdog; only ack waits advance it.
  assign tmr_load  = (state_d != state_q);
  assign tmr_count = ((state_q == S_WR_REQ)     && !host_interface.write_ack) ||
                     ((state_q == S_RD_REQ)     && !host_interface.read_ack)  ||
                     ((state_q == S_RD_RELEASE) &&  host_interface.read_ack);

  mmio_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clock     (clock),
    .reset     (reset),
    .enable_i  (enable_i),
    .load_i    (tmr_load),
    .count_i   (tmr_count),
    .expired_o (expired)
  );

  assign host_interface.read_req    = (state_q == S_RD_REQ) || (state_q == S_RD_RELEASE);
  assign host_interface.read_index  = index_q;
  assign host_interface.write_req   = (state_q == S_WR_REQ);
  assign host_interface.write_index = index_q;
  assign host_interface.write_data  = wdata_q;

  assign cmd_ready_o = (state_q == S_IDLE);
  assign wr_ready_o  = (state_q == S_WR_DATA);
  assign rd_valid_o  = (state_q == S_RD_PUSH);
  assign rd_data_o   = rdata_q;
  assign busy_o      = (state_q != S_IDLE);
  assign done_o      = (state_q == S_DONE) || (state_q == S_ERROR);
  assign error_o     = error_q;
  assign quiescent_o = (state_q == S_IDLE);
  assign state_o     = state_q;

endmodule

// File: tb/tb_mmio_burst_initiator.sv
// Directed bench for mmio_burst_initiator with a behavioural memory device
// that acks writes combinationally and runs the four-phase read handshake.
module tb_mmio_burst_initiator;
  import mmio_burst_initiator_pkg::*;

  localparam int TMO = 16;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic        enable_i = 1'b1;
  logic        cmd_valid_i = 1'b0, cmd_write_i = 1'b0;
  logic [31:0] cmd_base_i = '0;
  logic [15:0] cmd_count_i = '0;
  logic        wr_valid_i = 1'b0, rd_ready_i = 1'b0;
  logic [31:0] wr_data_i = '0;
  logic        cmd_ready_o, wr_ready_o, rd_valid_o, busy_o, done_o, error_o, quiescent_o;
  logic [31:0] rd_data_o;
  state_t      state_o;

  mmio_if mif ();

  mmio_burst_initiator #(.COUNT_WIDTH(16), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .enable_i(enable_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_base_i(cmd_base_i), .cmd_count_i(cmd_count_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
    .host_interface(mif),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .quiescent_o(quiescent_o),
    .state_o(state_o)
  );

  // ---------------- device model ----------------
  logic [31:0] mem [0:255];
  logic        dev_ack, dev_served, dev_mute = 1'b0;
  logic [31:0] dev_rdata;

  assign mif.write_ack = mif.write_req;
  assign mif.read_ack  = dev_ack;
  assign mif.read_data = dev_rdata;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      dev_ack    <= 1'b0;
      dev_served <= 1'b0;
      dev_rdata  <= '0;
    end else begin
      if (mif.read_req) begin
        if (!dev_ack && !dev_served && !dev_mute) begin
          dev_ack   <= 1'b1;
          dev_rdata <= mem[mif.read_index[7:0]];
        end else if (dev_ack) begin
          dev_ack    <= 1'b0;
          dev_served <= 1'b1;
        end
      end else begin
        dev_served <= 1'b0;
      end
      if (mif.write_req && mif.write_ack) mem[mif.write_index[7:0]] <= mif.write_data;
    end
  end

  // ---------------- protocol monitor ----------------
  int both_cnt = 0, rq_push_cnt = 0, early_drop = 0;
  logic prev_rreq = 1'b0, prev_rack = 1'b0;

  always @(negedge clock) begin
    if (mif.read_req && mif.write_req) both_cnt++;
    if (mif.read_req && rd_valid_o) rq_push_cnt++;
    if (reset && prev_rreq && !mif.read_req && prev_rack) early_drop++;
    prev_rreq = mif.read_req;
    prev_rack = mif.read_ack;
  end

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [31:0] wr_src_q[$];
  logic [31:0] obs_idx_q[$];
  logic [31:0] obs_rd_q[$];
  int          req_cycles, done_cnt, done_at, freeze_after = -1, frz_req;
  logic        err_at_done, timed_out, frz_rd_valid, frz_busy;
  state_t      frz_state;
  logic [31:0] frz_rd_data, got;
  int          vectors = 0, miscompares = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic run_cmd(input logic wr, input logic [31:0] base, input logic [15:0] cnt,
                         input bit rd_toggle, input int budget);
    int cyc;
    bit fin, acc, froze;
    obs_idx_q.delete(); obs_rd_q.delete();
    req_cycles = 0; done_cnt = 0; done_at = -1; err_at_done = 1'b0; timed_out = 1'b0;
    froze = 0; cyc = 0; fin = 0;
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_base_i = base; cmd_count_i = cnt;
    wr_valid_i = (wr_src_q.size() != 0);
    wr_data_i  = wr_valid_i ? wr_src_q[0] : '0;
    rd_ready_i = 1'b1;
    while (!fin && cyc < budget) begin
      if (freeze_after >= 0 && !froze && state_o == S_RD_PUSH && obs_rd_q.size() == freeze_after) begin
        froze = 1; enable_i = 1'b0; rd_ready_i = 1'b0; frz_req = 0;
        repeat (10) begin
          step();
          if (mif.read_req || mif.write_req) frz_req++;
        end
        frz_state = state_o; frz_rd_valid = rd_valid_o; frz_busy = busy_o; frz_rd_data = rd_data_o;
        enable_i = 1'b1; rd_ready_i = 1'b1;
      end
      acc = cmd_valid_i && cmd_ready_o;
      if (mif.write_req && mif.write_ack) obs_idx_q.push_back(mif.write_index);
      if (mif.read_req || mif.write_req) req_cycles++;
      if (rd_valid_o && rd_ready_i) obs_rd_q.push_back(rd_data_o);
      if (wr_valid_i && wr_ready_o) void'(wr_src_q.pop_front());
      if (done_o) begin
        done_cnt++; done_at = cyc; err_at_done = error_o; fin = 1;
      end
      step();
      cyc++;
      if (acc) cmd_valid_i = 1'b0;
      wr_valid_i = (wr_src_q.size() != 0);
      wr_data_i  = wr_valid_i ? wr_src_q[0] : '0;
      rd_ready_i = rd_toggle ? ((cyc % 2) == 1) : 1'b1;
    end
    cmd_valid_i = 1'b0; wr_valid_i = 1'b0;
    if (!fin) timed_out = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    vectors++; if (cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL rst_cmd_ready: got %b want 1", cmd_ready_o); end
    vectors++; if (busy_o !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy_o); end
    vectors++; if (done_o !== 1'b0 || error_o !== 1'b0) begin miscompares++; $display("FAIL rst_done_err: got %b%b want 00", done_o, error_o); end
    vectors++; if (mif.read_req !== 1'b0 || mif.write_req !== 1'b0) begin miscompares++; $display("FAIL rst_reqs: got %b%b want 00", mif.read_req, mif.write_req); end
    vectors++; if (rd_valid_o !== 1'b0 || wr_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_streams: got %b%b want 00", rd_valid_o, wr_ready_o); end
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    step();
    vectors++; if (state_o !== S_IDLE || quiescent_o !== 1'b1) begin miscompares++; $display("FAIL rst_idle: got state %0d q %b want 0 1", state_o, quiescent_o); end
  endtask

  task automatic test_write_burst();
    wr_src_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_cmd(1'b1, 32'h10, 16'd4, 1'b0, 100);
    vectors++; if (timed_out !== 1'b0 || done_cnt != 1) begin miscompares++; $display("FAIL wr_done: got %0d pulses want 1", done_cnt); end
    vectors++; if (req_cycles != 4) begin miscompares++; $display("FAIL wr_req_cycles: got %0d want 4", req_cycles); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (obs_idx_q.size() <= i || obs_idx_q[i] !== 32'h10 + 32'(i)) begin
        miscompares++; $display("FAIL wr_index[%0d]: got %h want %h", i, (obs_idx_q.size() > i) ? obs_idx_q[i] : 32'hx, 32'h10 + 32'(i));
      end
      vectors++;
      if (mem[8'h10 + 8'(i)] !== 32'hA + 32'(i)) begin
        miscompares++; $display("FAIL wr_mem[%0d]: got %h want %h", i, mem[8'h10 + 8'(i)], 32'hA + 32'(i));
      end
    end
    vectors++; if (err_at_done !== 1'b0) begin miscompares++; $display("FAIL wr_error: got %b want 0", err_at_done); end
    step();
    vectors++; if (done_o !== 1'b0 || cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL wr_done_width: got done %b ready %b want 0 1", done_o, cmd_ready_o); end
  endtask

  task automatic test_read_burst();
    logic [31:0] e;
    run_cmd(1'b0, 32'h10, 16'd4, 1'b1, 200);
    vectors++; if (timed_out !== 1'b0 || done_cnt != 1) begin miscompares++; $display("FAIL rd_done: got %0d pulses want 1", done_cnt); end
    vectors++; if (req_cycles != 12) begin miscompares++; $display("FAIL rd_req_cycles: got %0d want 12", req_cycles); end
    exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    vectors++; if (obs_rd_q.size() != 4) begin miscompares++; $display("FAIL rd_count: got %0d want 4", obs_rd_q.size()); end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      got = (obs_rd_q.size() != 0) ? obs_rd_q.pop_front() : 32'hx;
      vectors++; if (got !== e) begin miscompares++; $display("FAIL rd_data: got %h want %h", got, e); end
    end
  endtask

  task automatic test_zero_count();
    run_cmd(1'b1, 32'h40, 16'd0, 1'b0, 20);
    vectors++; if (done_at != 1) begin miscompares++; $display("FAIL zero_done_at: got %0d want 1", done_at); end
    vectors++; if (req_cycles != 0) begin miscompares++; $display("FAIL zero_reqs: got %0d want 0", req_cycles); end
    vectors++; if (err_at_done !== 1'b0) begin miscompares++; $display("FAIL zero_error: got %b want 0", err_at_done); end
  endtask

  task automatic test_wrap();
    logic [31:0] widx [3];
    widx = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000};
    wr_src_q = '{32'h1, 32'h2, 32'h3};
    run_cmd(1'b1, 32'hFFFF_FFFE, 16'd3, 1'b0, 100);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (obs_idx_q.size() <= i || obs_idx_q[i] !== widx[i]) begin
        miscompares++; $display("FAIL wrap_index[%0d]: got %h want %h", i, (obs_idx_q.size() > i) ? obs_idx_q[i] : 32'hx, widx[i]);
      end
    end
    vectors++; if (mem[8'h00] !== 32'h3) begin miscompares++; $display("FAIL wrap_mem0: got %h want 3", mem[8'h00]); end
  endtask

  task automatic test_timeout();
    dev_mute = 1'b1;
    run_cmd(1'b0, 32'h10, 16'd2, 1'b0, 100);
    vectors++; if (timed_out !== 1'b0) begin miscompares++; $display("FAIL tmo_done_seen: got no done want done"); end
    vectors++; if (err_at_done !== 1'b1) begin miscompares++; $display("FAIL tmo_error: got %b want 1", err_at_done); end
    vectors++; if (req_cycles != TMO) begin miscompares++; $display("FAIL tmo_req_cycles: got %0d want %0d", req_cycles, TMO); end
    step();
    vectors++; if (mif.read_req !== 1'b0 || error_o !== 1'b1 || cmd_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL tmo_after: got req %b err %b ready %b want 0 1 1", mif.read_req, error_o, cmd_ready_o);
    end
    dev_mute = 1'b0;
    run_cmd(1'b1, 32'h0, 16'd0, 1'b0, 20);
    vectors++; if (err_at_done !== 1'b0 || error_o !== 1'b0) begin miscompares++; $display("FAIL tmo_clear: got %b%b want 00", err_at_done, error_o); end
  endtask

  task automatic test_reset_mid_read();
    int cyc = 0, pushes = 0;
    cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_base_i = 32'h10; cmd_count_i = 16'd4; rd_ready_i = 1'b1;
    step();
    cmd_valid_i = 1'b0;
    while (cyc < 50 && !(pushes == 1 && mif.read_req)) begin
      if (rd_valid_o && rd_ready_i) pushes++;
      step(); cyc++;
    end
    vectors++; if (cyc >= 50) begin miscompares++; $display("FAIL rmid_reach_word2: got timeout want word 2 request"); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (mif.read_req !== 1'b0 || mif.write_req !== 1'b0) begin miscompares++; $display("FAIL rmid_reqs: got %b%b want 00", mif.read_req, mif.write_req); end
    vectors++; if (busy_o !== 1'b0 || cmd_ready_o !== 1'b1) begin miscompares++; $display("FAIL rmid_idle: got busy %b ready %b want 0 1", busy_o, cmd_ready_o); end
    @(negedge clock);
    reset = 1'b1;
    step();
    run_cmd(1'b0, 32'h12, 16'd1, 1'b0, 50);
    got = (obs_rd_q.size() != 0) ? obs_rd_q[0] : 32'hx;
    vectors++; if (got !== 32'hC) begin miscompares++; $display("FAIL rmid_recover: got %h want c", got); end
  endtask

  task automatic test_enable_freeze();
    freeze_after = 1;
    run_cmd(1'b0, 32'h10, 16'd4, 1'b0, 200);
    freeze_after = -1;
    vectors++; if (frz_state !== S_RD_PUSH || frz_rd_valid !== 1'b1 || frz_busy !== 1'b1) begin
      miscompares++; $display("FAIL frz_hold: got state %0d valid %b busy %b want 5 1 1", frz_state, frz_rd_valid, frz_busy);
    end
    vectors++; if (frz_rd_data !== 32'hB) begin miscompares++; $display("FAIL frz_data: got %h want b", frz_rd_data); end
    vectors++; if (frz_req != 0) begin miscompares++; $display("FAIL frz_reqs: got %0d want 0", frz_req); end
    exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
    foreach (exp_q[i]) begin
      got = (obs_rd_q.size() > i) ? obs_rd_q[i] : 32'hx;
      vectors++; if (got !== exp_q[i]) begin miscompares++; $display("FAIL frz_resume[%0d]: got %h want %h", i, got, exp_q[i]); end
    end
    exp_q.delete();
  endtask

  task automatic test_protocol();
    vectors++; if (both_cnt != 0) begin miscompares++; $display("FAIL proto_both_reqs: got %0d want 0", both_cnt); end
    vectors++; if (rq_push_cnt != 0) begin miscompares++; $display("FAIL proto_req_in_push: got %0d want 0", rq_push_cnt); end
    vectors++; if (early_drop != 0) begin miscompares++; $display("FAIL proto_early_drop: got %0d want 0", early_drop); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_zero_count();
    test_wrap();
    test_timeout();
    test_reset_mid_read();
    test_enable_freeze();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
